// File: rtl/proteus_pkg.sv
// Shared parameters and state encoding for the sb_packer bit-stream packer.
package proteus_pkg;

  localparam int PKG_N          = 16;
  localparam int PKG_SHIFT_BITS = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pack_state_t;

endpackage

// File: rtl/sb_packer.sv
// sb_packer: packs variable-precision values LSB-first into N-bit words.
// A 2N-bit accumulator collects masked values. Whenever N or more bits
// are present, the low N bits move to the output register. A flush
// request drains any partial word, zero-padded, and pulses o_flush_done.
module sb_packer
  import proteus_pkg::*;
#(
  parameter int N          = PKG_N,
  parameter int SHIFT_BITS = PKG_SHIFT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N-1:0]          i_data,
  input  logic [SHIFT_BITS-1:0] i_n,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N-1:0]          o_out,
  output logic                  o_flush_done
);

  localparam logic [2*N-1:0]        ONE_WIDE = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [SHIFT_BITS-1:0] N_NARROW = SHIFT_BITS'(N);
  localparam logic [SHIFT_BITS:0]   N_WIDE   = (SHIFT_BITS+1)'(N);

  pack_state_t           state_r;
  logic [2*N-1:0]        acc_r;
  logic [SHIFT_BITS-1:0] fill_r;

  logic [SHIFT_BITS-1:0] n_eff_s;
  logic [2*N-1:0]        mask_wide_s;
  logic [2*N-1:0]        data_wide_s;
  logic [2*N-1:0]        acc_next_s;
  logic [SHIFT_BITS:0]   fill_sum_s;
  logic [SHIFT_BITS-1:0] fill_wrap_s;
  logic                  word_full_s;
  logic                  out_free_s;
  logic                  accept_s;

  // Handshake: input is taken only in RUN, when the output register is or becomes free.
  assign out_free_s = !o_valid || i_ready;
  assign o_ready    = (state_r == ST_RUN) && out_free_s;
  assign accept_s   = i_valid && o_ready;

  // Datapath: clamp precision, mask the value, place it at the fill offset.
  always_comb begin
    n_eff_s = N_NARROW;
    if ((i_n == {SHIFT_BITS{1'b0}}) || ({1'b0, i_n} > N_WIDE)) begin
      n_eff_s = N_NARROW;
    end else begin
      n_eff_s = i_n;
    end
    mask_wide_s = (ONE_WIDE << n_eff_s) - ONE_WIDE;
    data_wide_s = {{N{1'b0}}, i_data} & mask_wide_s;
    acc_next_s  = acc_r | (data_wide_s << fill_r);
    fill_sum_s  = {1'b0, fill_r} + {1'b0, n_eff_s};
    word_full_s = (fill_sum_s >= N_WIDE);
    fill_wrap_s = fill_sum_s[SHIFT_BITS-1:0] - N_NARROW;
  end

  // Control FSM plus accumulator and registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      acc_r        <= {(2*N){1'b0}};
      fill_r       <= {SHIFT_BITS{1'b0}};
      o_valid      <= 1'b0;
      o_out        <= {N{1'b0}};
      o_flush_done <= 1'b0;
    end else begin
      o_flush_done <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            if (word_full_s) begin
              // Straddling values: low part completes this word, rest stays.
              o_out   <= acc_next_s[N-1:0];
              o_valid <= 1'b1;
              acc_r   <= acc_next_s >> N;
              fill_r  <= fill_wrap_s;
            end else begin
              acc_r  <= acc_next_s;
              fill_r <= fill_sum_s[SHIFT_BITS-1:0];
              if (i_ready) begin
                o_valid <= 1'b0;
              end
            end
          end else if (i_ready) begin
            o_valid <= 1'b0;
          end
          if (i_flush) begin
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // i_flush is ignored here; wait for the output register to free up.
          if (out_free_s) begin
            if (fill_r != {SHIFT_BITS{1'b0}}) begin
              o_out   <= acc_r[N-1:0];
              o_valid <= 1'b1;
              acc_r   <= {(2*N){1'b0}};
              fill_r  <= {SHIFT_BITS{1'b0}};
            end else begin
              o_valid <= 1'b0;
            end
            o_flush_done <= 1'b1;
            state_r      <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_packer.sv
// Directed self-checking bench for sb_packer (N=16, SHIFT_BITS=5).
module tb_sb_packer;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;
  logic [4:0]  i_n;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_out;
  logic        o_flush_done;

  int checks;
  int errors;
  logic [15:0] out_q[$];

  sb_packer #(.N(16), .SHIFT_BITS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_n          (i_n),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_out        (o_out),
    .o_flush_done (o_flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word the downstream side actually takes.
  always @(posedge clk) begin
    if (rst_n && o_valid && i_ready) out_q.push_back(o_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] n);
    int k;
    i_valid = 1'b1;
    i_data  = d;
    i_n     = n;
    #1;
    k = 0;
    while (!o_ready && k < 20) begin
      tick();
      k++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: o_ready stayed 0 for value %h", d);
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int k;
    k = 0;
    while (!o_flush_done && k < 10) begin
      tick();
      k++;
    end
    seen = o_flush_done;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL flush_done_timeout: no o_flush_done within 10 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_data = 16'h0000; i_n = 5'd0;
    i_flush = 1'b0; i_ready = 1'b1;
    #3;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", o_out); end
    checks++; if (o_flush_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_flush_done); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_basic();
    out_q.delete();
    send(16'h00AB, 5'd8);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_early: o_valid %b expected 0", o_valid); end
    send(16'h00CD, 5'd8);
    checks++; if (o_valid !== 1'b1 || o_out !== 16'hCDAB) begin errors++; $display("FAIL basic_word: got v=%b %h expected v=1 CDAB", o_valid, o_out); end
    tick();
    checks++; if (out_q.size() != 1 || out_q[0] !== 16'hCDAB) begin errors++; $display("FAIL basic_queue: size %0d expected 1 word CDAB", out_q.size()); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_clear: o_valid %b expected 0", o_valid); end
  endtask

  task automatic test_flush();
    bit seen;
    out_q.delete();
    for (int i = 0; i < 4; i++) send(16'h001F, 5'd5);
    checks++; if (o_out !== 16'hFFFF || o_valid !== 1'b1) begin errors++; $display("FAIL flush_full: got v=%b %h expected v=1 FFFF", o_valid, o_out); end
    pulse_flush();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0 in FLUSH", o_ready); end
    wait_done(seen);
    if (seen) begin
      checks++; if (o_out !== 16'h000F || o_valid !== 1'b1) begin errors++; $display("FAIL flush_word: got v=%b %h expected v=1 000F", o_valid, o_out); end
    end
    tick();
    checks++; if (o_flush_done !== 1'b0) begin errors++; $display("FAIL flush_pulse: done %b expected 0 after one cycle", o_flush_done); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_return: o_ready %b expected 1", o_ready); end
    checks++; if (out_q.size() != 2 || out_q[0] !== 16'hFFFF || out_q[1] !== 16'h000F) begin errors++; $display("FAIL flush_queue: size %0d expected FFFF,000F", out_q.size()); end
  endtask

  task automatic test_mask();
    out_q.delete();
    for (int i = 0; i < 4; i++) send(16'hFFF3, 5'd4);
    checks++; if (o_out !== 16'h3333 || o_valid !== 1'b1) begin errors++; $display("FAIL mask_word: got v=%b %h expected v=1 3333", o_valid, o_out); end
    tick();
  endtask

  task automatic test_backpressure();
    out_q.delete();
    i_ready = 1'b0;
    send(16'h1111, 5'd16);
    i_valid = 1'b1; i_data = 16'h2222; i_n = 5'd16;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_out !== 16'h1111 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold: cycle %0d got v=%b rdy=%b %h expected v=1 rdy=0 1111", i, o_valid, o_ready, o_out);
      end
      tick();
    end
    i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_release: o_ready %b expected 1", o_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_out !== 16'h2222) begin errors++; $display("FAIL stall_next: got %h expected 2222", o_out); end
    send(16'h3333, 5'd16);
    tick();
    checks++; if (out_q.size() != 3 || out_q[0] !== 16'h1111 || out_q[1] !== 16'h2222 || out_q[2] !== 16'h3333) begin
      errors++; $display("FAIL stall_order: size %0d expected 1111,2222,3333", out_q.size());
    end
  endtask

  task automatic test_n_bounds();
    send(16'h1234, 5'd0);
    checks++; if (o_out !== 16'h1234 || o_valid !== 1'b1) begin errors++; $display("FAIL n_zero: got v=%b %h expected v=1 1234", o_valid, o_out); end
    send(16'hBEEF, 5'd20);
    checks++; if (o_out !== 16'hBEEF || o_valid !== 1'b1) begin errors++; $display("FAIL n_over: got v=%b %h expected v=1 BEEF", o_valid, o_out); end
    tick();
  endtask

  task automatic test_flush_with_valid();
    bit seen;
    out_q.delete();
    send(16'h000A, 5'd4);
    send(16'h000B, 5'd4);
    send(16'h000C, 5'd4);
    i_valid = 1'b1; i_data = 16'h005D; i_n = 5'd8; i_flush = 1'b1;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    checks++; if (o_out !== 16'hDCBA || o_valid !== 1'b1) begin errors++; $display("FAIL fv_word1: got v=%b %h expected v=1 DCBA", o_valid, o_out); end
    wait_done(seen);
    if (seen) begin
      checks++; if (o_out !== 16'h0005 || o_valid !== 1'b1) begin errors++; $display("FAIL fv_word2: got v=%b %h expected v=1 0005", o_valid, o_out); end
    end
    tick();
    checks++; if (out_q.size() != 2 || out_q[0] !== 16'hDCBA || out_q[1] !== 16'h0005) begin errors++; $display("FAIL fv_queue: size %0d expected DCBA,0005", out_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(16'h0055, 5'd7);
    rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_out !== 16'h0000 || o_flush_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outs: got v=%b %h done=%b expected all 0", o_valid, o_out, o_flush_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_q.delete();
    pulse_flush();
    wait_done(seen);
    if (seen) begin
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noword: o_valid %b expected 0 at flush done", o_valid); end
    end
    tick();
    tick();
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL rstmid_queue: %0d words emitted expected 0", out_q.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_flush();
    test_mask();
    test_backpressure();
    test_n_bounds();
    test_flush_with_valid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
